// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction-format classes,
// width constants, and the decode issue scheduler state encoding.
package decode_pkg;

  localparam int INSTRUCTION_WIDTH  = 32;
  localparam int ADDRESS_SIZE       = 64;
  localparam int OPCODE_WIDTH       = 6;
  localparam int FORMAT_INDEX_RANGE = 5;

  // Instruction-format classes used by the decoder to pick a field layout.
  typedef enum logic [FORMAT_INDEX_RANGE-1:0] {
    INVALID = 5'd0,  A   = 5'd1,  B   = 5'd2,  D   = 5'd3,  DQ  = 5'd4,
    DS      = 5'd5,  DX  = 5'd6,  I   = 5'd7,  M   = 5'd8,  MD  = 5'd9,
    MDS     = 5'd10, SC  = 5'd11, VA  = 5'd12, VC  = 5'd13, VX  = 5'd14,
    X       = 5'd15, XFL = 5'd16, XFX = 5'd17, XL  = 5'd18, XO  = 5'd19,
    XS      = 5'd20, XX2 = 5'd21, XX3 = 5'd22, XX4 = 5'd23, Z22 = 5'd24,
    Z23     = 5'd25
  } format_class_e;

  // Scheduler states: IDLE (queue empty), RUN (work queued), FLUSH (one-cycle redirect).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

  // Primary opcode lives in the most significant bits (bit 0 is the MSB).
  function automatic logic [OPCODE_WIDTH-1:0] primary_opcode(
    input logic [0:INSTRUCTION_WIDTH-1] instr
  );
    return instr[0:OPCODE_WIDTH-1];
  endfunction

endpackage

// File: rtl/decode_issue_fifo.sv
// Instruction/address queue for the decode issue scheduler. Holds the
// storage array plus head, tail and occupancy; clear empties it in one edge.
module decode_issue_fifo
  import decode_pkg::*;
#(
  parameter int instructionWidth = INSTRUCTION_WIDTH,
  parameter int addressSize      = ADDRESS_SIZE,
  parameter int queueDepth       = 4,
  parameter int queuePtrWidth    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [0:instructionWidth-1] push_instr,
  input  logic [addressSize-1:0]     push_addr,
  output logic [0:instructionWidth-1] head_instr,
  output logic [addressSize-1:0]     head_addr,
  output logic [queuePtrWidth:0]     count,
  output logic [queuePtrWidth:0]     count_next
);

  logic [0:instructionWidth-1] instr_mem_r [queueDepth];
  logic [addressSize-1:0]      addr_mem_r  [queueDepth];
  logic [queuePtrWidth-1:0]    head_r;
  logic [queuePtrWidth-1:0]    tail_r;
  logic [queuePtrWidth:0]      count_r;
  logic [queuePtrWidth:0]      count_next_s;
  logic                        do_push_s;
  logic                        do_pop_s;

  assign head_instr = instr_mem_r[head_r];
  assign head_addr  = addr_mem_r[head_r];
  assign count      = count_r;
  assign count_next = count_next_s;

  // Qualify push/pop with clear and compute the post-edge occupancy.
  always_comb begin
    do_push_s    = 1'b0;
    do_pop_s     = 1'b0;
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {(queuePtrWidth+1){1'b0}};
    end else begin
      do_push_s = push;
      do_pop_s  = pop;
      if (push && !pop) begin
        count_next_s = count_r + (queuePtrWidth+1)'(1);
      end else if (pop && !push) begin
        count_next_s = count_r - (queuePtrWidth+1)'(1);
      end else begin
        count_next_s = count_r;
      end
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at queueDepth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {queuePtrWidth{1'b0}};
      tail_r  <= {queuePtrWidth{1'b0}};
      count_r <= {(queuePtrWidth+1){1'b0}};
    end else if (clear) begin
      head_r  <= {queuePtrWidth{1'b0}};
      tail_r  <= {queuePtrWidth{1'b0}};
      count_r <= {(queuePtrWidth+1){1'b0}};
    end else begin
      if (do_push_s) begin
        tail_r <= tail_r + queuePtrWidth'(1);
      end
      if (do_pop_s) begin
        head_r <= head_r + queuePtrWidth'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < queueDepth; e++) begin
        instr_mem_r[e] <= {instructionWidth{1'b0}};
        addr_mem_r[e]  <= {addressSize{1'b0}};
      end
    end else if (do_push_s) begin
      instr_mem_r[tail_r] <= push_instr;
      addr_mem_r[tail_r]  <= push_addr;
    end
  end

endmodule

// File: rtl/decode_issue_scheduler.sv
// Decode-stage sequencer: buffers fetched instruction/address pairs, issues
// at most one per cycle to the decoder, and turns a flush into a one-cycle
// fetch redirect while discarding queued work.
module decode_issue_scheduler
  import decode_pkg::*;
#(
  parameter int instructionWidth = INSTRUCTION_WIDTH,
  parameter int addressSize      = ADDRESS_SIZE,
  parameter int queueDepth       = 4,
  parameter int queuePtrWidth    = 2
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        fetchValid_i,
  input  logic [0:instructionWidth-1] fetchInstruction_i,
  input  logic [addressSize-1:0]      fetchAddress_i,
  output logic                        fetchReady_o,
  input  logic                        decodeStall_i,
  input  logic                        flush_i,
  input  logic [addressSize-1:0]      flushAddress_i,
  output logic                        decodeEnable_o,
  output logic [0:instructionWidth-1] decodeInstruction_o,
  output logic [addressSize-1:0]      decodeAddress_o,
  output logic                        redirectValid_o,
  output logic [addressSize-1:0]      redirectAddress_o,
  output logic [queuePtrWidth:0]      queueCount_o
);

  localparam logic [queuePtrWidth:0] DEPTH_COUNT = (queuePtrWidth+1)'(queueDepth);
  localparam logic [queuePtrWidth:0] ZERO_COUNT  = {(queuePtrWidth+1){1'b0}};

  sched_state_e                state_r;
  sched_state_e                state_next_s;
  logic                        fetch_ready_s;
  logic                        push_s;
  logic                        pop_s;
  logic [queuePtrWidth:0]      fifo_count_s;
  logic [queuePtrWidth:0]      fifo_count_next_s;
  logic [0:instructionWidth-1] head_instr_s;
  logic [addressSize-1:0]      head_addr_s;
  logic                        decode_enable_r;
  logic [0:instructionWidth-1] decode_instr_r;
  logic [addressSize-1:0]      decode_addr_r;
  logic                        redirect_valid_r;
  logic [addressSize-1:0]      redirect_addr_r;

  decode_issue_fifo #(
    .instructionWidth (instructionWidth),
    .addressSize      (addressSize),
    .queueDepth       (queueDepth),
    .queuePtrWidth    (queuePtrWidth)
  ) u_fifo (
    .clk        (clock_i),
    .rst_n      (reset_i),
    .clear      (flush_i),
    .push       (push_s),
    .pop        (pop_s),
    .push_instr (fetchInstruction_i),
    .push_addr  (fetchAddress_i),
    .head_instr (head_instr_s),
    .head_addr  (head_addr_s),
    .count      (fifo_count_s),
    .count_next (fifo_count_next_s)
  );

  // Ready depends only on registered state so fetch sees no combinational loop.
  always_comb begin
    fetch_ready_s = 1'b0;
    if ((fifo_count_s != DEPTH_COUNT) && (state_r != FLUSH)) begin
      fetch_ready_s = 1'b1;
    end else begin
      fetch_ready_s = 1'b0;
    end
  end

  // Push/pop qualification; a flush suppresses both on its edge.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush_i) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = fetchValid_i && fetch_ready_s;
      pop_s  = (state_r != FLUSH) && (fifo_count_s != ZERO_COUNT) && !decodeStall_i;
    end
  end

  // Next-state logic: flush dominates, FLUSH always falls back to IDLE.
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = FLUSH;
    end else begin
      case (state_r)
        IDLE: begin
          if (push_s) begin
            state_next_s = RUN;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN: begin
          if (fifo_count_next_s == ZERO_COUNT) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = RUN;
          end
        end
        FLUSH:   state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Scheduler state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue registers: enable pulses per pop, data holds between issues.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      decode_enable_r <= 1'b0;
      decode_instr_r  <= {instructionWidth{1'b0}};
      decode_addr_r   <= {addressSize{1'b0}};
    end else begin
      decode_enable_r <= pop_s;
      if (pop_s) begin
        decode_instr_r <= head_instr_s;
        decode_addr_r  <= head_addr_s;
      end
    end
  end

  // Redirect registers: strobe for each flush edge, newest address wins.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      redirect_valid_r <= 1'b0;
      redirect_addr_r  <= {addressSize{1'b0}};
    end else begin
      redirect_valid_r <= flush_i;
      if (flush_i) begin
        redirect_addr_r <= flushAddress_i;
      end
    end
  end

  assign fetchReady_o        = fetch_ready_s;
  assign decodeEnable_o      = decode_enable_r;
  assign decodeInstruction_o = decode_instr_r;
  assign decodeAddress_o     = decode_addr_r;
  assign redirectValid_o     = redirect_valid_r;
  assign redirectAddress_o   = redirect_addr_r;
  assign queueCount_o        = fifo_count_s;

endmodule

// File: tb/tb_decode_issue_scheduler.sv
// Self-checking bench for decode_issue_scheduler: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based model.
module tb_decode_issue_scheduler;

  localparam int IW = 32;
  localparam int AW = 64;

  logic          clk;
  logic          rst_n;
  logic          f_valid;
  logic [IW-1:0] f_instr;
  logic [AW-1:0] f_addr;
  logic          d_stall;
  logic          fl;
  logic [AW-1:0] fl_addr;
  logic          ready;
  logic          en;
  logic [IW-1:0] dinstr;
  logic [AW-1:0] daddr;
  logic          rv;
  logic [AW-1:0] raddr;
  logic [2:0]    qcount;

  decode_issue_scheduler dut (
    .clock_i             (clk),
    .reset_i             (rst_n),
    .fetchValid_i        (f_valid),
    .fetchInstruction_i  (f_instr),
    .fetchAddress_i      (f_addr),
    .fetchReady_o        (ready),
    .decodeStall_i       (d_stall),
    .flush_i             (fl),
    .flushAddress_i      (fl_addr),
    .decodeEnable_o      (en),
    .decodeInstruction_o (dinstr),
    .decodeAddress_o     (daddr),
    .redirectValid_o     (rv),
    .redirectAddress_o   (raddr),
    .queueCount_o        (qcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] ad;
  } ent_t;

  // Behavioural model state
  ent_t          mq[$];
  logic          m_en;
  logic [IW-1:0] m_di;
  logic [AW-1:0] m_da;
  logic          m_rv;
  logic [AW-1:0] m_ra;
  logic          m_flush;

  int total = 0;
  int bad   = 0;
  logic check_on = 1'b0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (mq.size() != 4) && !m_flush;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_di = '0; m_da = '0;
    m_rv = 1'b0; m_ra = '0; m_flush = 1'b0;
  endtask

  // Apply one clock edge's worth of the behavioural rules.
  task automatic model_update();
    logic rdy;
    logic do_pop;
    ent_t e;
    rdy = model_ready();
    if (fl) begin
      mq.delete();
      m_en = 1'b0;
      m_rv = 1'b1;
      m_ra = fl_addr;
      m_flush = 1'b1;
    end else begin
      do_pop = !m_flush && (mq.size() > 0) && !d_stall;
      m_en = do_pop;
      if (do_pop) begin
        e = mq.pop_front();
        m_di = e.ins;
        m_da = e.ad;
      end
      if (f_valid && rdy) begin
        e.ins = f_instr;
        e.ad  = f_addr;
        mq.push_back(e);
      end
      m_rv = 1'b0;
      m_flush = 1'b0;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_on) begin
      chk("ready",  {63'd0, ready},  {63'd0, model_ready()});
      chk("enable", {63'd0, en},     {63'd0, m_en});
      chk("instr",  {32'd0, dinstr}, {32'd0, m_di});
      chk("addr",   daddr,           m_da);
      chk("rvalid", {63'd0, rv},     {63'd0, m_rv});
      chk("raddr",  raddr,           m_ra);
      chk("count",  {61'd0, qcount}, 64'(mq.size()));
    end
  end

  // One cycle: drive inputs after the falling edge, clock, update model.
  task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] ad,
                       input logic st, input logic f, input logic [AW-1:0] fa);
    f_valid = v; f_instr = ins; f_addr = ad;
    d_stall = st; fl = f; fl_addr = fa;
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 32'd0, 64'd0, st, 1'b0, 64'd0);
  endtask

  task automatic single_push_scenario();
    cycle(1'b1, 32'h38600001, 64'h1000, 1'b0, 1'b0, 64'd0);
    chk("s1_en_after_push", {63'd0, en}, 64'd0);
    chk("s1_count_after_push", {61'd0, qcount}, 64'd1);
    idle(1'b0);
    chk("s1_en_issue", {63'd0, en}, 64'd1);
    chk("s1_instr", {32'd0, dinstr}, 64'h38600001);
    chk("s1_addr", daddr, 64'h1000);
    idle(1'b0);
    chk("s1_en_drop", {63'd0, en}, 64'd0);
    chk("s1_count_zero", {61'd0, qcount}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    f_valid = 1'b0; f_instr = '0; f_addr = '0;
    d_stall = 1'b0; fl = 1'b0; fl_addr = '0;
    model_reset();
    @(negedge clk);
    chk("reset_en", {63'd0, en}, 64'd0);
    chk("reset_count", {61'd0, qcount}, 64'd0);
    chk("reset_raddr", raddr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_on = 1'b1;

    // Single push, issue latency
    single_push_scenario();

    // Stall fills the queue to four, then drains in order
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 32'hA000_0000 + 32'(k), 64'h2000 + 64'(k * 4), 1'b1, 1'b0, 64'd0);
    chk("s2_count_full", {61'd0, qcount}, 64'd4);
    chk("s2_ready_full", {63'd0, ready}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      chk("s2_drain_en", {63'd0, en}, 64'd1);
      chk("s2_drain_instr", {32'd0, dinstr}, {32'd0, 32'hA000_0000 + 32'(k)});
    end
    idle(1'b0);
    chk("s2_done_en", {63'd0, en}, 64'd0);

    // Steady push and pop at occupancy two, wrapping pointers
    cycle(1'b1, 32'hB000_0000, 64'h3000, 1'b1, 1'b0, 64'd0);
    cycle(1'b1, 32'hB000_0001, 64'h3004, 1'b1, 1'b0, 64'd0);
    for (int k = 2; k < 12; k++)
      cycle(1'b1, 32'hB000_0000 + 32'(k), 64'h3000 + 64'(k * 4), 1'b0, 1'b0, 64'd0);
    chk("s3_count_steady", {61'd0, qcount}, 64'd2);
    chk("s3_last_issued", {32'd0, dinstr}, 64'hB000_0009);
    repeat (3) idle(1'b0);

    // Flush with queued work and a same-edge push
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'hC000_0000 + 32'(k), 64'h4000 + 64'(k * 4), 1'b1, 1'b0, 64'd0);
    cycle(1'b1, 32'hDEAD_BEEF, 64'h5000, 1'b0, 1'b1, 64'h2000);
    chk("s4_rvalid", {63'd0, rv}, 64'd1);
    chk("s4_raddr", raddr, 64'h2000);
    chk("s4_count", {61'd0, qcount}, 64'd0);
    chk("s4_en", {63'd0, en}, 64'd0);
    chk("s4_ready_flush", {63'd0, ready}, 64'd0);
    idle(1'b0);
    chk("s4_rvalid_drop", {63'd0, rv}, 64'd0);
    repeat (2) idle(1'b0);

    // Back-to-back flushes
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h2000);
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h3000);
    chk("s5_rvalid_second", {63'd0, rv}, 64'd1);
    chk("s5_raddr_newest", raddr, 64'h3000);
    idle(1'b0);
    chk("s5_rvalid_drop", {63'd0, rv}, 64'd0);
    chk("s5_ready_idle", {63'd0, ready}, 64'd1);

    // Asynchronous reset while issuing with two entries left
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'hE000_0000 + 32'(k), 64'h6000 + 64'(k * 4), 1'b1, 1'b0, 64'd0);
    idle(1'b0);
    chk("s6_pre_en", {63'd0, en}, 64'd1);
    chk("s6_pre_count", {61'd0, qcount}, 64'd2);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_en", {63'd0, en}, 64'd0);
    chk("s6_rst_instr", {32'd0, dinstr}, 64'd0);
    chk("s6_rst_addr", daddr, 64'd0);
    chk("s6_rst_count", {61'd0, qcount}, 64'd0);
    chk("s6_rst_rv", {63'd0, rv}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    single_push_scenario();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            32'($urandom),
            {32'($urandom), 32'($urandom)},
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            {32'($urandom), 32'($urandom)});
    end
    repeat (6) idle(1'b0);

    check_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
